switch_debounce: RTL and testbench

SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

---
 rtl/switch_debounce.sv | 137 +++++++++++++
 tb/tb_switch_debounce.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce.sv
// -----------------------------------------------------------------------------
// switch_debounce
//
// Debounces WIDTH independent mechanical switch inputs. Each raw level is
// brought into the clk domain by a two-flop synchronizer. A per-bit counter
// then requires DEBOUNCE_CYCLES consecutive synchronized samples that
// disagree with the current debounced level before the new level is
// accepted. Any sample that agrees with the debounced level restarts the
// count, so short glitches never reach sw_clean.
//
// A raw level held stable appears on sw_clean DEBOUNCE_CYCLES+2 rising edges
// after the first edge that samples it: two synchronizer edges, then
// DEBOUNCE_CYCLES counting/accept edges.
//
// Optional feature (compile-time macro SWITCH_DEBOUNCE_EDGE_CAPTURE_EN):
//   When defined, edge_capture holds a sticky per-bit flag that is set the
//   cycle after sw_changed pulses and cleared the cycle after edge_clear is
//   high. A set and a clear arriving together leave the flag set, so a
//   change is never lost to a clear issued for an earlier change.
//   When undefined, edge_capture is tied to 0, edge_clear is ignored and no
//   capture flops exist; the ports stay so the instantiation never changes.
//
// Parameters
//   WIDTH            number of independent switch bits
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a new level
//   CNT_W            per-bit counter width; 1 <= DEBOUNCE_CYCLES <= 2**CNT_W
//
// Ports
//   clk           system clock, rising-edge active
//   reset_n       asynchronous active-low reset; deassert synchronously to clk
//   sw_raw        raw, asynchronous switch levels from the board pins
//   sw_clean      registered debounced levels (feeds the switch PIO in_port)
//   sw_changed    registered one-cycle pulse per bit when sw_clean updates
//   edge_clear    per-bit clear of edge_capture, active-high, sampled each clk
//   edge_capture  sticky per-bit change flags (0 when feature compiled out)
// -----------------------------------------------------------------------------
module switch_debounce #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_changed,
    input  logic [WIDTH-1:0] edge_clear,
    output logic [WIDTH-1:0] edge_capture
);

    // Terminal count: the counter value at which the next disagreeing sample
    // is the DEBOUNCE_CYCLES-th in a row and the new level is accepted.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (1 << CNT_W)) begin : g_bad_param
            $error("switch_debounce: DEBOUNCE_CYCLES must satisfy 1 <= DEBOUNCE_CYCLES <= 2**CNT_W");
        end
    endgenerate

    // Next counter value. The count only advances while the sample disagrees
    // with the debounced level; it returns to zero on agreement and on
    // acceptance, so it saturates at CNT_MAX and can never wrap.
    function automatic logic [CNT_W-1:0] cnt_next(
        input logic [CNT_W-1:0] cnt_cur,
        input logic             mismatch
    );
        if (!mismatch || (cnt_cur == CNT_MAX)) begin
            return '0;
        end
        return cnt_cur + 1'b1;
    endfunction

    logic [WIDTH-1:0] sync_p0;
    logic [WIDTH-1:0] sync_p1;
    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] clean_nxt;

    // ---- stage p0/p1: two-flop synchronizer; sync_p1 is the sampled level ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= sw_raw;
            sync_p1 <= sync_p0;
        end
    end

    // ---- stage p2: per-bit stability counters and acceptance ----
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [CNT_W-1:0] cnt;
        logic             mismatch;

        assign mismatch  = sync_p1[i] ^ sw_clean[i];
        assign accept[i] = mismatch && (cnt == CNT_MAX);
        // On acceptance the sample is the complement of the old level, so
        // toggling is the same as loading the sample.
        assign clean_nxt[i] = sw_clean[i] ^ accept[i];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt <= '0;
            end else begin
                cnt <= cnt_next(cnt, mismatch);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_clean   <= '0;
            sw_changed <= '0;
        end else begin
            sw_clean   <= clean_nxt;
            sw_changed <= accept;
        end
    end

    // ---- stage p3: sticky change flags ----
`ifdef SWITCH_DEBOUNCE_EDGE_CAPTURE_EN
    // Set wins over clear so a change arriving with a clear is kept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture <= '0;
        end else begin
            edge_capture <= (edge_capture & ~edge_clear) | sw_changed;
        end
    end
`else
    logic unused_edge_clear;

    assign edge_capture      = '0;
    assign unused_edge_clear = ^edge_clear;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// -----------------------------------------------------------------------------
// tb_switch_debounce
//
// Bench for switch_debounce with WIDTH=10, DEBOUNCE_CYCLES=4, CNT_W=3.
// A behavioural reference keeps the synchronized sample history and accepts a
// new level for a bit once the last DEBOUNCE_CYCLES samples all disagree with
// the current debounced level. A compare process checks every output on every
// falling edge against that reference; directed sequences add literal
// expectations for reset, latency, glitch rejection, capture/clear
// interaction and mid-count reset. Randomized switch bouncing follows.
// -----------------------------------------------------------------------------
module tb_switch_debounce;

    localparam int WIDTH = 10;
    localparam int DEB   = 4;
    localparam int CW    = 3;

`ifdef SWITCH_DEBOUNCE_EDGE_CAPTURE_EN
    localparam bit CAP_EN = 1'b1;
`else
    localparam bit CAP_EN = 1'b0;
`endif

    logic             clk        = 1'b0;
    logic             reset_n    = 1'b0;
    logic [WIDTH-1:0] sw_raw     = '0;
    logic [WIDTH-1:0] edge_clear = '0;
    logic [WIDTH-1:0] sw_clean;
    logic [WIDTH-1:0] sw_changed;
    logic [WIDTH-1:0] edge_capture;

    switch_debounce #(
        .WIDTH          (WIDTH),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (CW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sw_raw      (sw_raw),
        .sw_clean    (sw_clean),
        .sw_changed  (sw_changed),
        .edge_clear  (edge_clear),
        .edge_capture(edge_capture)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: actual=0x%03h required=0x%03h at t=%0t",
                         name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // ---------------- behavioural reference ----------------
    logic [WIDTH-1:0] m_sync1   = '0;
    logic [WIDTH-1:0] m_s       = '0;
    logic [WIDTH-1:0] m_clean   = '0;
    logic [WIDTH-1:0] m_changed = '0;
    logic [WIDTH-1:0] m_cap     = '0;
    logic [WIDTH-1:0] hist[$];
    logic [WIDTH-1:0] n_clean;
    logic [WIDTH-1:0] n_chg;
    logic [WIDTH-1:0] n_cap;
    bit               run_ok;

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_sync1   = '0;
                m_s       = '0;
                m_clean   = '0;
                m_changed = '0;
                m_cap     = '0;
                hist.delete();
            end else begin
                hist.push_back(m_s);
                if (hist.size() > DEB) void'(hist.pop_front());
                n_clean = m_clean;
                n_chg   = '0;
                if (hist.size() == DEB) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        run_ok = 1'b1;
                        for (int j = 0; j < DEB; j++)
                            if (hist[j][i] == m_clean[i]) run_ok = 1'b0;
                        if (run_ok) begin
                            n_clean[i] = ~m_clean[i];
                            n_chg[i]   = 1'b1;
                        end
                    end
                end
                n_cap     = CAP_EN ? ((m_cap & ~edge_clear) | m_changed) : '0;
                m_s       = m_sync1;
                m_sync1   = sw_raw;
                m_clean   = n_clean;
                m_changed = n_chg;
                m_cap     = n_cap;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            check("model_sw_clean", sw_clean, m_clean);
            check("model_sw_changed", sw_changed, m_changed);
            check("model_edge_capture", edge_capture, m_cap);
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random stimulus ----------------
    int hold[WIDTH];

    initial begin
        // reset state
        step(3);
        check("reset_clean", sw_clean, 10'h000);
        check("reset_changed", sw_changed, 10'h000);
        check("reset_capture", edge_capture, 10'h000);
        reset_n = 1'b1;

        // idle with switches low
        for (int k = 0; k < 20; k++) begin
            step(1);
            check("idle_clean", sw_clean, 10'h000);
            check("idle_changed", sw_changed, 10'h000);
            check("idle_capture", edge_capture, 10'h000);
        end

        // 3-cycle glitch on bit 3 is rejected
        sw_raw = 10'h008;
        for (int k = 0; k < 13; k++) begin
            if (k == 3) sw_raw = 10'h000;
            step(1);
            check("glitch_clean", sw_clean, 10'h000);
            check("glitch_changed", sw_changed, 10'h000);
        end

        // bit 0 rises: accepted exactly 6 edges later
        sw_raw = 10'h001;
        for (int k = 1; k <= 5; k++) begin
            step(1);
            check("lat_clean_early", sw_clean, 10'h000);
        end
        step(1);
        check("lat_clean", sw_clean, 10'h001);
        check("lat_changed", sw_changed, 10'h001);
        step(1);
        check("lat_pulse_end", sw_changed, 10'h000);
        check("lat_capture", edge_capture, CAP_EN ? 10'h001 : 10'h000);

        // falling change on bit 0 with edge_clear in the same cycle
        sw_raw = 10'h000;
        step(5);
        check("fall_clean_early", sw_clean, 10'h001);
        step(1);
        check("fall_clean", sw_clean, 10'h000);
        check("fall_changed", sw_changed, 10'h001);
        edge_clear = 10'h001;
        step(1);
        check("setclr_capture", edge_capture, CAP_EN ? 10'h001 : 10'h000);
        check("setclr_changed", sw_changed, 10'h000);
        step(1);
        check("clr_capture", edge_capture, 10'h000);
        edge_clear = 10'h000;

        // all switches high while in reset
        #2 reset_n = 1'b0;
        #1;
        check("rst2_clean", sw_clean, 10'h000);
        sw_raw = 10'h3FF;
        step(3);
        reset_n = 1'b1;
        step(5);
        check("rel_clean_early", sw_clean, 10'h000);
        step(1);
        check("rel_clean", sw_clean, 10'h3FF);
        check("rel_changed", sw_changed, 10'h3FF);
        step(1);
        check("rel_pulse_end", sw_changed, 10'h000);
        check("rel_capture", edge_capture, CAP_EN ? 10'h3FF : 10'h000);

        // reset in the middle of a count on bit 5
        sw_raw = 10'h3DF;
        step(4);
        check("mid_clean_hold", sw_clean, 10'h3FF);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_clean", sw_clean, 10'h000);
        check("mid_rst_changed", sw_changed, 10'h000);
        check("mid_rst_capture", edge_capture, 10'h000);
        step(2);
        reset_n = 1'b1;
        step(5);
        check("mid_clean_early", sw_clean, 10'h000);
        step(1);
        check("mid_clean", sw_clean, 10'h3DF);
        check("mid_changed", sw_changed, 10'h3DF);

        // randomized bouncing
        for (int i = 0; i < WIDTH; i++) hold[i] = 0;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (hold[i] == 0) begin
                    sw_raw[i] = ~sw_raw[i];
                    hold[i]   = $urandom_range(1, 9);
                end else begin
                    hold[i]--;
                end
            end
            edge_clear = WIDTH'($urandom & $urandom & $urandom);
            if (k == 1500) #2 reset_n = 1'b0;
            if (k == 1503) reset_n = 1'b1;
            step(1);
        end
        edge_clear = '0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
